gray_updown_counter: RTL and testbench
======================================

GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter SATURATE, default 0: 0 = wrap at the ends, 1 = hold at the ends.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement; sampled only when en=1.
REQ-007 The block SHALL have port load, input, 1 bit: load request.
REQ-008 The block SHALL have port load_gray, input, WIDTH bits: Gray-coded value to load.
REQ-009 The block SHALL have port gray, output, WIDTH bits: registered count, Gray-coded.
REQ-010 The block SHALL have port bin, output, WIDTH bits: registered count, binary.
REQ-011 The block SHALL have port at_max, output, 1 bit: bin equals all-ones.
REQ-012 The block SHALL have port at_min, output, 1 bit: bin equals zero.
REQ-013 The block SHALL have port wrap, output, 1 bit: one-cycle pulse marking a wrap (SATURATE=0) or a blocked step (SATURATE=1).

Function
REQ-014 Internal state SHALL be one binary register cnt[WIDTH-1:0]; bin SHALL equal cnt.
REQ-015 gray SHALL be a register updated in the same cycle as cnt with the value next_cnt ^ (next_cnt >> 1), so that gray and bin always describe the same count.
REQ-016 at_max and at_min SHALL be registered and consistent with the bin value shown in the same cycle.
REQ-017 Priority SHALL be load > en > hold.
REQ-018 load=1 SHALL set cnt to the binary conversion of load_gray, MSB-first prefix XOR (b[i] = XOR of g[WIDTH-1:i]), with 1-cycle latency; wrap=0 on a load cycle.
REQ-019 en=1, up=1, load=0 SHALL set cnt to cnt+1, modulo 2^WIDTH.
REQ-020 en=1, up=0, load=0 SHALL set cnt to cnt-1, modulo 2^WIDTH.
REQ-021 en=0, load=0 SHALL hold cnt and gray, with wrap=0.
REQ-022 When SATURATE=0, a step from all-ones up to 0, or from 0 down to all-ones, SHALL pulse wrap for exactly the one cycle in which the new value is presented.
REQ-023 When SATURATE=1, an up step at all-ones or a down step at 0 SHALL leave cnt unchanged and pulse wrap for one cycle; wrap SHALL repeat every cycle the blocked request persists.
REQ-024 Each count step SHALL change exactly one bit of gray, including across wrap.
REQ-025 A load of a value equal to the current count SHALL be accepted silently: no output change and wrap=0.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force cnt=0, gray=0, bin=0, at_min=1, at_max=0 and wrap=0.
REQ-027 Reset asserted mid-count or mid-load SHALL discard the pending update.
REQ-028 After rst_n deassertion, the first rising edge SHALL apply normal priority rules.

Structure
REQ-029 Package gray_pkg SHALL hold the WIDTH default, a bin2gray function and a gray2bin function; no other shared typedefs are needed.
REQ-030 The load-path conversion SHALL be a separate combinational sub-module gray2bin, parameterised by WIDTH, reusable stand-alone.
REQ-031 There SHALL be no latches and no combinational path from inputs to outputs.

Verification
REQ-032 The bench SHALL cover reset plus up-count: rst_n low, then en=1 up=1 for 16 cycles (WIDTH=4) -> bin 1..15 then 0, gray 0001,0011,0010,...,1000 then 0000, wrap high only on the 15->0 cycle.
REQ-033 The bench SHALL cover down-count from reset: en=1 up=0 -> bin=15, gray=1000, wrap=1 in the first cycle, then bin=14, gray=1001.
REQ-034 The bench SHALL cover load priority: load=1 load_gray=1101 en=1 -> next cycle bin=1001, gray=1101, wrap=0.
REQ-035 The bench SHALL cover saturation: SATURATE=1, load gray 1000 (bin 15), then en=1 up=1 for 3 cycles -> bin stays 15, at_max=1, wrap=1 each cycle.
REQ-036 The bench SHALL cover asynchronous reset: rst_n pulsed low between clock edges while counting at bin=7 -> outputs zero before the next edge, at_min=1.
REQ-037 The bench SHALL cover the exhaustive Gray check: WIDTH=6 free-run up for 64 cycles -> popcount(gray ^ previous gray)==1 every cycle, gray2bin(gray)==bin every cycle.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants and Gray/binary conversion helpers for the Gray up/down counter.
// The functions work on 32-bit values; narrower callers zero-extend and truncate.
package gray_pkg;

  localparam int DEFAULT_WIDTH = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] binVal);
    return binVal ^ (binVal >> 1);
  endfunction

  // Zero-extended upper bits leave the MSB-first prefix XOR unaffected.
  function automatic logic [31:0] gray2bin(input logic [31:0] grayVal);
    logic [31:0] binVal;
    binVal[31] = grayVal[31];
    for (int i = 30; i >= 0; i--) begin
      binVal[i] = binVal[i+1] ^ grayVal[i];
    end
    return binVal;
  endfunction

endpackage

// File: rtl/gray_updown_counter_gray2bin.sv
// Stand-alone combinational Gray-to-binary converter (MSB-first prefix XOR).
// Purely combinational; usable outside the counter at any width.
module gray2bin
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    bin_o = '0;
    bin_o[WIDTH-1] = gray_i[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down counter holding a binary count with registered Gray, end-flag and wrap outputs.
// Every output is a register fed from the same next-state value, so they always agree.
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             atMax_q, atMax_d;
  logic             atMin_q, atMin_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] loadBin;

  gray2bin #(
    .WIDTH(WIDTH)
  ) uLoadConv (
    .gray_i(load_gray),
    .bin_o (loadBin)
  );

  // Load beats counting; at an end the step either wraps or, when saturating, is blocked.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = loadBin;
    end else if (en) begin
      if (up) begin
        if (cnt_q == MAX_VAL) begin
          wrap_d = 1'b1;
          cnt_d  = SATURATE ? cnt_q : '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          wrap_d = 1'b1;
          cnt_d  = SATURATE ? cnt_q : MAX_VAL;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
    gray_d  = WIDTH'(bin2gray(32'(cnt_d)));
    atMax_d = (cnt_d == MAX_VAL);
    atMin_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      gray_q  <= '0;
      atMax_q <= 1'b0;
      atMin_q <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      gray_q  <= gray_d;
      atMax_q <= atMax_d;
      atMin_q <= atMin_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bin    = cnt_q;
  assign gray   = gray_q;
  assign at_max = atMax_q;
  assign at_min = atMin_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Scoreboard bench for gray_updown_counter: three instances (4-bit wrap, 4-bit saturate, 6-bit wrap)
// share one stimulus stream; expected responses are queued and checked by an independent monitor.
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [5:0] loadGray = '0;

  logic [3:0] gray0, bin0, gray1, bin1;
  logic [5:0] gray2, bin2;
  logic       atMax0, atMin0, wrap0;
  logic       atMax1, atMin1, wrap1;
  logic       atMax2, atMin2, wrap2;

  int compared = 0;
  int mismatched = 0;
  int cycleCount = 0;
  logic [5:0] prevGray2 = '0;
  event sampleEv;

  typedef struct {
    int         dut;
    logic [5:0] bin;
    logic [5:0] gray;
    logic       atMax;
    logic       atMin;
    logic       wrap;
    bit         stepCheck;
    int         due;
    string      name;
  } expT;

  expT sbQ[$];

  // Hand-computed Gray codes for bin 1..15 then 0 on a 4-bit count.
  localparam logic [3:0] UP_GRAY [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                          4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                          4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                          4'b1011, 4'b1001, 4'b1000, 4'b0000};

  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_gray(loadGray[3:0]),
    .gray(gray0), .bin(bin0), .at_max(atMax0), .at_min(atMin0), .wrap(wrap0)
  );

  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_gray(loadGray[3:0]),
    .gray(gray1), .bin(bin1), .at_max(atMax1), .at_min(atMin1), .wrap(wrap1)
  );

  gray_updown_counter #(.WIDTH(6), .SATURATE(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_gray(loadGray),
    .gray(gray2), .bin(bin2), .at_max(atMax2), .at_min(atMin2), .wrap(wrap2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  function automatic logic [5:0] g2b(input logic [5:0] g);
    logic [5:0] b;
    b[5] = g[5];
    for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic pushExpect(input int dut, input int binV, input int grayV, input bit wr,
                            input bit sc, input int due, input string nm);
    expT e;
    int maxV;
    maxV        = (dut == 2) ? 63 : 15;
    e.dut       = dut;
    e.bin       = 6'(binV);
    e.gray      = 6'(grayV);
    e.atMax     = (binV == maxV);
    e.atMin     = (binV == 0);
    e.wrap      = wr;
    e.stepCheck = sc;
    e.due       = due;
    e.name      = nm;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic e, input logic u, input logic l, input logic [5:0] lg);
    @(negedge clk);
    en       = e;
    up       = u;
    load     = l;
    loadGray = lg;
  endtask

  // Reset is asserted between edges and checked before the next rising edge.
  task automatic resetPulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) pushExpect(d, 0, 0, 1'b0, 1'b0, cycleCount, "asyncReset");
    ->sampleEv;
    @(negedge clk);
    en    = 1'b0;
    load  = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic checkOutput(input expT e);
    logic [5:0] aBin, aGray;
    logic       aMax, aMin, aWrap;
    case (e.dut)
      0:       begin aBin = {2'b00, bin0}; aGray = {2'b00, gray0}; aMax = atMax0; aMin = atMin0; aWrap = wrap0; end
      1:       begin aBin = {2'b00, bin1}; aGray = {2'b00, gray1}; aMax = atMax1; aMin = atMin1; aWrap = wrap1; end
      default: begin aBin = bin2; aGray = gray2; aMax = atMax2; aMin = atMin2; aWrap = wrap2; end
    endcase
    compared++;
    if (aBin !== e.bin || aGray !== e.gray || aMax !== e.atMax || aMin !== e.atMin || aWrap !== e.wrap) begin
      mismatched++;
      $display("[TB] FAIL %s dut%0d @cycle %0d: got bin=%0d gray=%b max=%b min=%b wrap=%b, want bin=%0d gray=%b max=%b min=%b wrap=%b",
               e.name, e.dut, cycleCount, aBin, aGray, aMax, aMin, aWrap,
               e.bin, e.gray, e.atMax, e.atMin, e.wrap);
    end
    if (e.stepCheck) begin
      compared++;
      if ($countones(aGray ^ prevGray2) != 1) begin
        mismatched++;
        $display("[TB] FAIL grayOneBitStep @cycle %0d: got prev=%b now=%b, want exactly one bit changed",
                 cycleCount, prevGray2, aGray);
      end
      compared++;
      if (g2b(aGray) !== aBin) begin
        mismatched++;
        $display("[TB] FAIL grayMatchesBin @cycle %0d: got gray2bin(gray)=%0d, want bin=%0d",
                 cycleCount, g2b(aGray), aBin);
      end
    end
    if (e.dut == 2) prevGray2 = aGray;
  endtask

  // Monitor: pops every expectation whose due cycle has arrived.
  initial begin
    expT e;
    forever begin
      @(negedge clk or sampleEv);
      while (sbQ.size() > 0 && sbQ[0].due <= cycleCount) begin
        e = sbQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b;
    $display("[TB] starting gray_updown_counter bench");
    resetPulse();

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
      pushExpect(0, (i + 1) % 16, UP_GRAY[i], (i == 15), 1'b0, cycleCount + 1, "upCount");
    end

    resetPulse();
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0);
    pushExpect(0, 15, 4'b1000, 1'b1, 1'b0, cycleCount + 1, "downWrap");
    pushExpect(1, 0, 4'b0000, 1'b1, 1'b0, cycleCount + 1, "satMinBlock");
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0);
    pushExpect(0, 14, 4'b1001, 1'b0, 1'b0, cycleCount + 1, "downStep");
    pushExpect(1, 0, 4'b0000, 1'b1, 1'b0, cycleCount + 1, "satMinRepeat");

    applyStimulus(1'b1, 1'b0, 1'b1, 6'b001101);
    pushExpect(0, 9, 4'b1101, 1'b0, 1'b0, cycleCount + 1, "loadPriority");
    applyStimulus(1'b1, 1'b1, 1'b1, 6'b001101);
    pushExpect(0, 9, 4'b1101, 1'b0, 1'b0, cycleCount + 1, "loadSameValue");
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd0);
    pushExpect(0, 9, 4'b1101, 1'b0, 1'b0, cycleCount + 1, "holdIdle");

    applyStimulus(1'b0, 1'b0, 1'b1, 6'b001000);
    pushExpect(1, 15, 4'b1000, 1'b0, 1'b0, cycleCount + 1, "satLoadMax");
    pushExpect(0, 15, 4'b1000, 1'b0, 1'b0, cycleCount + 1, "loadMax");
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
    pushExpect(0, 0, 4'b0000, 1'b1, 1'b0, cycleCount + 1, "upWrapAfterLoad");
    pushExpect(1, 15, 4'b1000, 1'b1, 1'b0, cycleCount + 1, "satMaxBlock");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
      pushExpect(1, 15, 4'b1000, 1'b1, 1'b0, cycleCount + 1, "satMaxRepeat");
    end

    applyStimulus(1'b0, 1'b1, 1'b1, 6'b000101);
    pushExpect(0, 6, 4'b0101, 1'b0, 1'b0, cycleCount + 1, "loadSix");
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
    pushExpect(0, 7, 4'b0100, 1'b0, 1'b0, cycleCount + 1, "countSeven");
    resetPulse();
    pushExpect(0, 0, 4'b0000, 1'b0, 1'b0, cycleCount + 1, "resetDiscardsStep");
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
    pushExpect(0, 1, 4'b0001, 1'b0, 1'b0, cycleCount + 1, "firstEdgeAfterReset");

    resetPulse();
    for (int k = 1; k <= 64; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 6'd0);
      b = k % 64;
      pushExpect(2, b, b ^ (b >> 1), (k == 64), 1'b1, cycleCount + 1, "gray6Run");
    end

    for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(negedge clk);
    #1;
    if (sbQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboardDrain: got %0d entries left, want 0", sbQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
